// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for the integer register file: merges ALU, load and mul/div
// results onto the single write port and tracks busy destinations of long ops.
module regfile_wb_sched #(
    parameter int MAX_LONG = 4,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [63:0]   alu_wd,
    input  logic          ld_valid,
    input  logic [4:0]    ld_rd,
    input  logic [63:0]   ld_wd,
    output logic          ld_ready,
    input  logic          md_valid,
    input  logic [4:0]    md_rd,
    input  logic [63:0]   md_wd,
    output logic          md_ready,
    input  logic          issue_valid,
    input  logic          issue_long,
    input  logic [4:0]    issue_rs1,
    input  logic [4:0]    issue_rs2,
    input  logic [4:0]    issue_rd,
    output logic          issue_stall,
    output logic          wb_wen,
    output logic [4:0]    wb_rd,
    output logic [63:0]   wb_wd,
    output logic [CW-1:0] long_outstanding
);
    logic        rr;
    logic        long_pend;
    logic [31:0] busy_q;
    logic [31:0] busy_next;
    logic        grant_ld;
    logic        grant_md;
    logic        grant_long;
    logic [4:0]  grant_rd;
    logic [63:0] grant_wd;
    logic        at_cap;
    logic        issue_accept;

    assign grant_ld   = !rst && !alu_valid && ld_valid && (!md_valid || !rr);
    assign grant_md   = !rst && !alu_valid && md_valid && (!ld_valid || rr);
    assign grant_long = grant_ld || grant_md;
    assign grant_rd   = grant_ld ? ld_rd : md_rd;
    assign grant_wd   = grant_ld ? ld_wd : md_wd;
    assign ld_ready   = grant_ld;
    assign md_ready   = grant_md;

    assign at_cap       = (long_outstanding == CW'(MAX_LONG));
    assign issue_stall  = issue_valid && (busy_q[issue_rs1] || busy_q[issue_rs2] ||
                                          busy_q[issue_rd] || (issue_long && at_cap));
    assign issue_accept = issue_valid && issue_long && !issue_stall;

    // Clear follows the registered write (long_pend + wb_rd); a same-index set overrides it.
    always_comb begin
        busy_next = busy_q;
        if (long_pend && wb_rd != 5'd0)
            busy_next[wb_rd] = 1'b0;
        if (issue_accept && issue_rd != 5'd0)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wen           <= 1'b0;
            wb_rd            <= 5'd0;
            wb_wd            <= 64'd0;
            long_pend        <= 1'b0;
            rr               <= 1'b0;
            busy_q           <= 32'd0;
            long_outstanding <= '0;
        end else begin
            wb_wen    <= 1'b0;
            long_pend <= 1'b0;
            if (alu_valid) begin
                wb_wen <= (alu_rd != 5'd0);
                wb_rd  <= alu_rd;
                wb_wd  <= alu_wd;
            end else if (grant_long) begin
                wb_wen    <= (grant_rd != 5'd0);
                wb_rd     <= grant_rd;
                wb_wd     <= grant_wd;
                long_pend <= 1'b1;
            end

            if (grant_ld)
                rr <= 1'b1;
            else if (grant_md)
                rr <= 1'b0;

            busy_q <= busy_next;

            if (issue_accept && !grant_long)
                long_outstanding <= long_outstanding + CW'(1);
            else if (!issue_accept && grant_long && long_outstanding != '0)
                long_outstanding <= long_outstanding - CW'(1);
        end
    end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: arbitration, scoreboard stalls, x0 rules,
// outstanding cap and reset behaviour, against hand-computed expectations.
module tb_regfile_wb_sched;
    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_wd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [63:0] ld_wd;
    logic        ld_ready;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [63:0] md_wd;
    logic        md_ready;
    logic        issue_valid;
    logic        issue_long;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_stall;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [63:0] wb_wd;
    logic [3:0]  long_outstanding;

    int checks   = 0;
    int failures = 0;

    regfile_wb_sched #(.MAX_LONG(4), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_wd(ld_wd), .ld_ready(ld_ready),
        .md_valid(md_valid), .md_rd(md_rd), .md_wd(md_wd), .md_ready(md_ready),
        .issue_valid(issue_valid), .issue_long(issue_long),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_stall(issue_stall),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .long_outstanding(long_outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; ld_valid = 0; md_valid = 0;
        issue_valid = 0; issue_long = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    endtask

    task automatic issue(input logic lng, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        issue_valid = 1; issue_long = lng;
        issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    endtask

    initial begin
        idle();
        alu_rd = 0; alu_wd = 0; ld_rd = 0; ld_wd = 0; md_rd = 0; md_wd = 0;

        // Reset with every request active
        rst = 1;
        alu_valid = 1; alu_rd = 5'd2; alu_wd = 64'h2;
        ld_valid = 1; ld_rd = 5'd5; ld_wd = 64'h11;
        md_valid = 1; md_rd = 5'd6; md_wd = 64'h66;
        issue(1, 0, 0, 5'd8);
        tick(); tick();
        check("rst_wen", wb_wen, 0);
        check("rst_wrd", wb_rd, 0);
        check("rst_ldrdy", ld_ready, 0);
        check("rst_mdrdy", md_ready, 0);
        check("rst_cnt", long_outstanding, 0);

        rst = 0; idle();
        ld_valid = 1; ld_rd = 5'd5; ld_wd = 64'h11;
        settle();
        check("first_ldrdy", ld_ready, 1);
        tick();
        ld_valid = 0;
        check("first_wen", wb_wen, 1);
        check("first_wrd", wb_rd, 5);
        check("first_wwd", wb_wd, 64'h11);
        check("cnt_no_underflow", long_outstanding, 0);

        // Pointer back to load-preferred
        rst = 1; tick(); rst = 0;

        // Contention: ALU first, then load, then mul/div
        alu_valid = 1; alu_rd = 5'd3; alu_wd = 64'hA;
        ld_valid = 1; ld_rd = 5'd4; ld_wd = 64'h44;
        md_valid = 1; md_rd = 5'd6; md_wd = 64'h66;
        settle();
        check("cont_ldrdy_alu", ld_ready, 0);
        check("cont_mdrdy_alu", md_ready, 0);
        tick();
        alu_valid = 0;
        check("cont_t1_rd", wb_rd, 3);
        check("cont_t1_wd", wb_wd, 64'hA);
        check("cont_t1_wen", wb_wen, 1);
        settle();
        check("cont_t1_ldrdy", ld_ready, 1);
        check("cont_t1_mdrdy", md_ready, 0);
        tick();
        ld_valid = 0;
        check("cont_t2_rd", wb_rd, 4);
        check("cont_t2_wd", wb_wd, 64'h44);
        settle();
        check("cont_t2_mdrdy", md_ready, 1);
        tick();
        md_valid = 0;
        check("cont_t3_rd", wb_rd, 6);
        check("cont_t3_wd", wb_wd, 64'h66);

        // Round-robin alternation ld, md, ld, md
        ld_valid = 1; ld_rd = 5'd8; ld_wd = 64'h88;
        md_valid = 1; md_rd = 5'd9; md_wd = 64'h99;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_ldrdy", ld_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_mdrdy", md_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            check("rr_wrd", wb_rd, (i % 2 == 0) ? 8 : 9);
        end
        idle();

        // RAW stall on a long destination
        issue(1, 0, 0, 5'd7);
        settle();
        check("raw_issue_stall", issue_stall, 0);
        tick();
        check("raw_cnt1", long_outstanding, 1);
        issue(0, 5'd7, 0, 5'd10);
        settle();
        check("raw_stall_a", issue_stall, 1);
        tick();
        check("raw_stall_b", issue_stall, 1);
        ld_valid = 1; ld_rd = 5'd7; ld_wd = 64'h77;
        settle();
        check("raw_ldrdy", ld_ready, 1);
        check("raw_stall_T", issue_stall, 1);
        tick();
        ld_valid = 0;
        check("raw_t1_stall", issue_stall, 1);
        check("raw_t1_wrd", wb_rd, 7);
        check("raw_t1_wd", wb_wd, 64'h77);
        check("raw_t1_cnt", long_outstanding, 0);
        tick();
        check("raw_t2_stall", issue_stall, 0);
        check("idle_wen", wb_wen, 0);
        check("idle_hold_rd", wb_rd, 7);
        idle();

        // x0 handling
        issue(1, 0, 0, 5'd0);
        settle();
        check("x0_issue_stall", issue_stall, 0);
        tick();
        check("x0_cnt_inc", long_outstanding, 1);
        issue(0, 5'd0, 5'd0, 5'd0);
        settle();
        check("x0_no_busy", issue_stall, 0);
        idle();
        ld_valid = 1; ld_rd = 5'd0; ld_wd = 64'h55;
        settle();
        check("x0_ldrdy", ld_ready, 1);
        tick();
        ld_valid = 0;
        check("x0_wen", wb_wen, 0);
        check("x0_cnt_dec", long_outstanding, 0);

        // Outstanding cap
        for (int r = 1; r <= 4; r++) begin
            issue(1, 0, 0, 5'(r));
            settle();
            check("cap_fill_stall", issue_stall, 0);
            tick();
        end
        check("cap_cnt4", long_outstanding, 4);
        issue(1, 0, 0, 5'd9);
        settle();
        check("cap_5th_stall", issue_stall, 1);
        tick();
        check("cap_cnt_hold", long_outstanding, 4);
        ld_valid = 1; ld_rd = 5'd1; ld_wd = 64'h1;
        settle();
        check("cap_stall_grant", issue_stall, 1);
        tick();
        ld_valid = 0;
        check("cap_cnt3", long_outstanding, 3);
        md_valid = 1; md_rd = 5'd2; md_wd = 64'h22;
        settle();
        check("cap_slot_free", issue_stall, 0);
        check("cap_mdrdy", md_ready, 1);
        tick();
        md_valid = 0;
        check("cap_inc_dec_hold", long_outstanding, 3);
        issue(1, 0, 0, 5'd10);
        settle();
        check("cap_x10_stall", issue_stall, 0);
        tick();
        check("cap_cnt_full", long_outstanding, 4);
        issue(1, 0, 0, 5'd11);
        settle();
        check("cap_full_stall", issue_stall, 1);

        // Reset mid-operation with a load waiting
        idle();
        ld_valid = 1; ld_rd = 5'd3; ld_wd = 64'h33;
        rst = 1;
        settle();
        check("mid_rst_ldrdy", ld_ready, 0);
        tick();
        rst = 0; ld_valid = 0;
        check("mid_rst_wen", wb_wen, 0);
        check("mid_rst_cnt", long_outstanding, 0);
        issue(0, 5'd3, 5'd4, 5'd9);
        settle();
        check("mid_rst_busy_clr", issue_stall, 0);
        issue(0, 5'd10, 5'd1, 5'd2);
        settle();
        check("mid_rst_busy_clr2", issue_stall, 0);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
